sensor_scanner: RTL and testbench
=================================

# sensor_scanner

Acquisition front end for the baggage-height path: sequentially reads the four height sensors through one shared ADC channel using a four-phase req/ack handshake. It presents all four readings on `sensor1`..`sensor4` as one atomically updated snapshot for the height-averaging logic. A channel that fails to answer within a timeout is reported as 8'h00, the value the height logic already treats as a dead sensor.

## Interface
- SETTLE_CYCLES, 3, cycles the mux select is held stable before each request (1..15)
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting in either handshake phase (1..255)

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin one 4-channel scan; sampled only in IDLE
- adc_sel  output  2  channel select, 0..3 → sensor1..sensor4
- adc_req  output  1  conversion request (four-phase)
- adc_ack  input  1  conversion acknowledge; adc_data valid while high
- adc_data  input  8  conversion result
- sensor1..sensor4  output  8 each  committed readings
- valid  output  1  one-cycle pulse when a new snapshot is committed
- busy  output  1  high from the cycle after start is accepted until IDLE is re-entered
- timeout_err  output  1  sticky: at least one channel timed out in the last scan

## Operation
- States: IDLE, SETTLE, REQ, ACKLOW, COMMIT. All outputs are registered.
- IDLE: when `start`=1, clear the channel index, the shadow registers and `timeout_err`, then go to SETTLE. `start` is ignored in every other state.
- SETTLE: drive `adc_sel` to the channel index with `adc_req`=0 for exactly SETTLE_CYCLES cycles, then go to REQ.
- REQ: `adc_req`=1.
  - If `adc_ack` is sampled high, store `adc_data` into the shadow register for the current channel at that edge, then go to ACKLOW.
  - If `adc_ack` is still low after TIMEOUT_CYCLES cycles in REQ, store 8'h00, set `timeout_err`, then go to ACKLOW.
- ACKLOW: `adc_req`=0. Wait for `adc_ack`=0, or for TIMEOUT_CYCLES cycles; the timeout case also sets `timeout_err`.
  - Channel index < 3: increment the index, go to SETTLE.
  - Channel index = 3: go to COMMIT.
- COMMIT: copy all four shadow registers to `sensor1`..`sensor4` in the same edge, assert `valid` for this one cycle, go to IDLE.
- `sensorN` change only in COMMIT. They hold the previous snapshot throughout a scan, so a partial scan is never visible.
- Data with value 8'h00 from the ADC is stored unchanged; it is not flagged as an error.
- Counters: one settle counter and one timeout counter, both cleared on every state entry. The timeout counter is 8 bits wide and saturates at TIMEOUT_CYCLES.
- `adc_sel` holds its value from the start of SETTLE until SETTLE is next re-entered. It is 0 in IDLE.

## Timing
- Reset values: state=IDLE; `adc_sel`=0, `adc_req`=0, `sensor1`..`sensor4`=8'h00, `valid`=0, `busy`=0, `timeout_err`=0. Shadow registers and counters are 0.
- Reset mid-scan: all of the above takes effect immediately. `adc_req` drops asynchronously and no partial snapshot is committed.
- Handshake rules:
  - `adc_req` rises only from SETTLE and falls only after `ack` is sampled high or on timeout.
  - A new `adc_req` is never raised while `adc_ack` is high, except after an ACKLOW timeout.
- Latency, responder with `adc_ack`=`adc_req` (zero wait): per channel SETTLE_CYCLES+2 cycles.
  - `valid` is high in cycle 4·(SETTLE_CYCLES+2)+1 after the edge that sampled `start`: cycle 21 at defaults.
  - `busy` falls on the following edge.
- Each extra ack delay cycle, in either phase, adds one cycle.
- `start` held high continuously: a new scan is accepted in the IDLE cycle right after COMMIT. Scans run back-to-back with one idle cycle between them.
- `timeout_err` stays set until the next accepted `start`. It is valid at the same time as the `valid` pulse.

## Test plan
- Reset → all outputs 0 → `start` pulse, zero-wait responder returning 8'h10, 8'h20, 8'h30, 8'h40 for sel 0..3 → `valid` in cycle 21; sensor1..4 = 10/20/30/40; `timeout_err`=0.
- Responder delays ack 5 cycles in REQ and 2 cycles in ACKLOW on every channel → `valid` in cycle 4·(5+7)+1 = 49; data correct; `adc_req` never high while `adc_ack` high at REQ entry.
- Channel 2 never acks, TIMEOUT_CYCLES=8 → sensor3=8'h00, the other channels correct, `timeout_err`=1. Next scan with a healthy responder clears `timeout_err`.
- `sensorN` preset to 8'hAA by a prior scan; `rst_n` pulsed low during channel 1 REQ → `adc_req` drops immediately; outputs 0; no `valid`; FSM in IDLE.
- `start` pulsed repeatedly during a scan → ignored; exactly one `valid`. `start` held high → `valid` pulses every 22 cycles at defaults.
- ADC returns 8'h00 on channel 0 with a normal ack → sensor1=8'h00 and `timeout_err`=0.

Source files
------------

// File: rtl/sensor_scanner_if.sv
// Shared ADC channel: mux select plus four-phase req/ack conversion handshake.
// The scanner drives select/request; the converter answers with ack/data.
interface sensor_scanner_if;
    logic [1:0] adc_sel;
    logic       adc_req;
    logic       adc_ack;
    logic [7:0] adc_data;

    modport master (output adc_sel, output adc_req, input adc_ack, input adc_data);
    modport slave  (input adc_sel, input adc_req, output adc_ack, output adc_data);
endinterface

// File: rtl/sensor_scanner.sv
// Scans four height sensors through one shared ADC and publishes them as an
// atomic snapshot; channels that miss the handshake deadline read as 8'h00.
module sensor_scanner #(
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    sensor_scanner_if.master adc,
    output logic [7:0]       sensor1,
    output logic [7:0]       sensor2,
    output logic [7:0]       sensor3,
    output logic [7:0]       sensor4,
    output logic             valid,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [2:0] {IDLE, SETTLE, REQ, ACKLOW, COMMIT} state_t;

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [1:0] sel_q, sel_d;
    logic       req_q, req_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] shadow_q [4];
    logic [7:0] shadow_d [4];
    logic [7:0] sens_q [4];
    logic [7:0] sens_d [4];
    logic       tmo_hit;

    assign tmo_hit = (tmo_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        sel_d    = sel_q;
        req_d    = req_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        err_d    = err_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        sens_d   = sens_q;

        if ((state_q == REQ || state_q == ACKLOW) && tmo_q != 8'(TIMEOUT_CYCLES))
            tmo_d = tmo_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    ch_d    = 2'd0;
                    sel_d   = 2'd0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    for (int i = 0; i < 4; i++) shadow_d[i] = 8'h00;
                end
            end
            SETTLE: begin
                if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            REQ: begin
                if (adc.adc_ack) begin
                    shadow_d[ch_q] = adc.adc_data;
                    req_d          = 1'b0;
                    state_d        = ACKLOW;
                end else if (tmo_hit) begin
                    shadow_d[ch_q] = 8'h00;
                    err_d          = 1'b1;
                    req_d          = 1'b0;
                    state_d        = ACKLOW;
                end
            end
            ACKLOW: begin
                if (!adc.adc_ack || tmo_hit) begin
                    // Still high here means the release phase timed out.
                    if (adc.adc_ack) err_d = 1'b1;
                    if (ch_q == 2'd3) begin
                        state_d = COMMIT;
                        valid_d = 1'b1;
                        sens_d  = shadow_q;
                    end else begin
                        ch_d    = ch_q + 2'd1;
                        sel_d   = ch_q + 2'd1;
                        state_d = SETTLE;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sel_d   = 2'd0;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            settle_d = 4'd0;
            tmo_d    = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 2'd0;
            sel_q    <= 2'd0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            settle_q <= 4'd0;
            tmo_q    <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 8'h00;
                sens_q[i]   <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            sel_q    <= sel_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            sens_q   <= sens_d;
        end
    end

    assign adc.adc_sel  = sel_q;
    assign adc.adc_req  = req_q;
    assign sensor1      = sens_q[0];
    assign sensor2      = sens_q[1];
    assign sensor3      = sens_q[2];
    assign sensor4      = sens_q[3];
    assign valid        = valid_q;
    assign busy         = busy_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_sensor_scanner.sv
// Bench for sensor_scanner: configurable ADC responder plus a snapshot
// scoreboard (expected values and valid cycle pushed at start, checked on valid).
`timescale 1ns/1ps
module tb_sensor_scanner;
    localparam int SETTLE = 3;
    localparam int TMO    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic       valid, busy, timeout_err;

    sensor_scanner_if adc_if ();

    sensor_scanner #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .adc        (adc_if),
        .sensor1    (sensor1),
        .sensor2    (sensor2),
        .sensor3    (sensor3),
        .sensor4    (sensor4),
        .valid      (valid),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s [4];
        logic       err;
        int         vcyc;
    } exp_t;

    exp_t       exp_q [$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    int         cyc = 0;
    int         req_dly = 0;
    int         rel_dly = 0;
    int         dead_ch = -1;
    int         proto_err = 0;
    logic [7:0] resp_val [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Responder: acts on the falling edge so the DUT samples settled values.
    initial begin
        int  wcnt;
        bit  req_prev;
        wcnt = 0;
        req_prev = 1'b0;
        adc_if.adc_ack  = 1'b0;
        adc_if.adc_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                adc_if.adc_ack = 1'b0;
                wcnt = 0;
                req_prev = 1'b0;
            end else begin
                if (adc_if.adc_req && !req_prev && adc_if.adc_ack) proto_err++;
                req_prev = adc_if.adc_req;
                if (adc_if.adc_req && !adc_if.adc_ack) begin
                    if (int'(adc_if.adc_sel) != dead_ch) begin
                        if (wcnt >= req_dly) begin
                            adc_if.adc_ack  = 1'b1;
                            adc_if.adc_data = resp_val[adc_if.adc_sel];
                            wcnt = 0;
                        end else begin
                            wcnt++;
                        end
                    end
                end else if (!adc_if.adc_req && adc_if.adc_ack) begin
                    if (wcnt >= rel_dly) begin
                        adc_if.adc_ack = 1'b0;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_cycle", cyc, e.vcyc);
                    chk("sensor1", sensor1, e.s[0]);
                    chk("sensor2", sensor2, e.s[1]);
                    chk("sensor3", sensor3, e.s[2]);
                    chk("sensor4", sensor4, e.s[3]);
                    chk("timeout_err", timeout_err, e.err);
                end
            end
        end
    end

    function automatic int exp_lat(input int rd, input int ld, input int dead);
        int l;
        l = 1;
        for (int c = 0; c < 4; c++)
            l += SETTLE + ((c == dead) ? (TMO + 1) : (rd + 1) + (ld + 1));
        return l;
    endfunction

    function automatic exp_t make_exp(input logic [7:0] v0, input logic [7:0] v1,
                                      input logic [7:0] v2, input logic [7:0] v3,
                                      input int dead, input int vcyc);
        exp_t e;
        e.s[0] = (dead == 0) ? 8'h00 : v0;
        e.s[1] = (dead == 1) ? 8'h00 : v1;
        e.s[2] = (dead == 2) ? 8'h00 : v2;
        e.s[3] = (dead == 3) ? 8'h00 : v3;
        e.err  = (dead >= 0);
        e.vcyc = vcyc;
        return e;
    endfunction

    task automatic configure(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                             input logic [7:0] v3, input int rd, input int ld, input int dead);
        resp_val[0] = v0; resp_val[1] = v1; resp_val[2] = v2; resp_val[3] = v3;
        req_dly = rd; rel_dly = ld; dead_ch = dead;
    endtask

    task automatic wait_valid(input int target, input int budget);
        for (int i = 0; i < budget && n_valid < target; i++) begin
            @(negedge clk);
            #1;
        end
        chk("valid_count", n_valid, target);
    endtask

    task automatic run_scan(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                            input logic [7:0] v3, input int rd, input int ld, input int dead);
        int target;
        configure(v0, v1, v2, v3, rd, ld, dead);
        target = n_valid + 1;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(make_exp(v0, v1, v2, v3, dead, cyc + exp_lat(rd, ld, dead)));
        @(negedge clk);
        start = 1'b0;
        wait_valid(target, 400);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int target;
        int base;
        configure(8'h10, 8'h20, 8'h30, 8'h40, 0, 0, -1);

        // Reset values, held in reset then after release.
        repeat (3) @(negedge clk);
        chk("rst_sel", adc_if.adc_sel, 2'd0);
        chk("rst_req", adc_if.adc_req, 1'b0);
        chk("rst_sensor1", sensor1, 8'h00);
        chk("rst_sensor4", sensor4, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Zero-wait scan with busy timing around the valid pulse.
        target = n_valid + 1;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(make_exp(8'h10, 8'h20, 8'h30, 8'h40, -1, cyc + 21));
        @(negedge clk);
        start = 1'b0;
        chk("busy_cycle1", busy, 1'b1);
        wait_valid(target, 100);
        @(negedge clk);
        chk("busy_after_commit", busy, 1'b0);
        chk("valid_one_cycle", valid, 1'b0);

        // Slow responder: 5 extra cycles in REQ, 2 in ACKLOW.
        run_scan(8'h5A, 8'hA5, 8'h3C, 8'hC3, 5, 2, -1);

        // Dead channel 2, then a healthy scan clears the error.
        run_scan(8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 2);
        run_scan(8'h01, 8'h02, 8'h03, 8'h04, 0, 0, -1);

        // Zero data is a legitimate reading.
        run_scan(8'h00, 8'h11, 8'h22, 8'h33, 0, 0, -1);

        // Preset snapshot, then reset in the middle of channel 1 REQ.
        run_scan(8'hAA, 8'hAA, 8'hAA, 8'hAA, 0, 0, -1);
        configure(8'h77, 8'h77, 8'h77, 8'h77, 5, 0, -1);
        base = n_valid;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60 && !(adc_if.adc_req && adc_if.adc_sel == 2'd1); i++) @(negedge clk);
        chk("reached_ch1_req", {adc_if.adc_req, adc_if.adc_sel}, {1'b1, 2'd1});
        #1 rst_n = 1'b0;
        #1;
        chk("async_req_drop", adc_if.adc_req, 1'b0);
        chk("rst_mid_sensor1", sensor1, 8'h00);
        chk("rst_mid_sensor3", sensor3, 8'h00);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_sel", adc_if.adc_sel, 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("no_valid_after_reset", n_valid, base);
        chk("idle_after_reset", busy, 1'b0);

        // Start pulses during a scan are ignored.
        configure(8'h21, 8'h43, 8'h65, 8'h87, 0, 0, -1);
        base = n_valid;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(make_exp(8'h21, 8'h43, 8'h65, 8'h87, -1, cyc + 21));
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k < 16; k++) begin
            @(negedge clk);
            start = (k % 4 == 0);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("single_valid", n_valid, base + 1);

        // Start held high: back-to-back scans, 22 cycles apart.
        base = n_valid;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(make_exp(8'h21, 8'h43, 8'h65, 8'h87, -1, cyc + 21));
        exp_q.push_back(make_exp(8'h21, 8'h43, 8'h65, 8'h87, -1, cyc + 43));
        wait_valid(base + 2, 100);
        start = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("held_start_valids", n_valid, base + 2);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("req_while_ack", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
